// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: drives one outstanding instruction-memory
// request at a time and queues returned words in a 2-entry FIFO towards
// decode. Redirects flush the queue and steer the fetch PC, squashing any
// response still in flight.
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC  = 32'hBFC0_0000,
    parameter int unsigned BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        mem_en_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_ready_i,
    input  logic [31:0] mem_data_i,
    output logic        inst_valid_o,
    output logic [31:0] inst_o,
    output logic [31:0] inst_pc_o
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] FETCH  = 2'd1;
    localparam logic [1:0] HOLD   = 2'd2;
    localparam logic [1:0] SQUASH = 2'd3;

    localparam logic [1:0] FullCnt = 2'(BUF_DEPTH);

    logic [1:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pend_q, pend_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] bpc0_q, bpc0_d, bpc1_q, bpc1_d;
    logic [31:0] bin0_q, bin0_d, bin1_q, bin1_d;

    logic [31:0] target;
    logic        deq;
    logic        enq;
    logic [1:0]  cnt_mid;
    logic        unused_redirect_lsbs;

    // Low address bits of a redirect are not part of the word address.
    assign target               = {redirect_pc_i[31:2], 2'b00};
    assign unused_redirect_lsbs = ^redirect_pc_i[1:0];

    assign deq     = (cnt_q != 2'd0) && !stall_i;
    assign enq     = (state_q == FETCH) && mem_ready_i && !redirect_i;
    assign cnt_mid = cnt_q - 2'(deq);

    // Output decode from registered state only.
    always_comb begin
        mem_en_o     = (state_q == FETCH) || (state_q == SQUASH);
        mem_addr_o   = pc_q;
        inst_valid_o = (cnt_q != 2'd0);
        inst_o       = inst_valid_o ? bin0_q : 32'd0;
        inst_pc_o    = inst_valid_o ? bpc0_q : 32'd0;
    end

    // FSM, fetch PC and pending redirect target.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        pend_d  = pend_q;
        case (state_q)
            IDLE: begin
                state_d = FETCH;
                if (redirect_i) begin
                    pc_d = target;
                end
            end
            FETCH: begin
                if (redirect_i) begin
                    if (mem_ready_i) begin
                        pc_d = target;
                    end else begin
                        pend_d  = target;
                        state_d = SQUASH;
                    end
                end else if (mem_ready_i) begin
                    pc_d    = pc_q + 32'd4;
                    state_d = ((cnt_mid + 2'd1) < FullCnt) ? FETCH : HOLD;
                end
            end
            HOLD: begin
                if (redirect_i) begin
                    pc_d    = target;
                    state_d = FETCH;
                end else if (cnt_mid < FullCnt) begin
                    state_d = FETCH;
                end
            end
            SQUASH: begin
                // The in-flight response is dropped; the newest target wins.
                if (redirect_i) begin
                    pend_d = target;
                end
                if (mem_ready_i) begin
                    pc_d    = redirect_i ? target : pend_q;
                    state_d = FETCH;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Instruction FIFO: entry 0 is the head; dequeue shifts entry 1 down.
    always_comb begin
        cnt_d  = cnt_q;
        bpc0_d = bpc0_q;
        bin0_d = bin0_q;
        bpc1_d = bpc1_q;
        bin1_d = bin1_q;
        if (redirect_i) begin
            cnt_d = 2'd0;
        end else begin
            if (deq) begin
                bpc0_d = bpc1_q;
                bin0_d = bin1_q;
            end
            if (enq) begin
                if (cnt_mid == 2'd0) begin
                    bpc0_d = pc_q;
                    bin0_d = mem_data_i;
                end else begin
                    bpc1_d = pc_q;
                    bin1_d = mem_data_i;
                end
            end
            cnt_d = cnt_mid + 2'(enq);
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            pend_q  <= 32'd0;
            cnt_q   <= 2'd0;
            bpc0_q  <= 32'd0;
            bin0_q  <= 32'd0;
            bpc1_q  <= 32'd0;
            bin1_q  <= 32'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            pend_q  <= pend_d;
            cnt_q   <= cnt_d;
            bpc0_q  <= bpc0_d;
            bin0_q  <= bin0_d;
            bpc1_q  <= bpc1_d;
            bin1_q  <= bin1_d;
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: reset, streaming, stall/hold, squash,
// redirects, PC wrap and asynchronous reset mid-request.
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        mem_en_o;
    logic [31:0] mem_addr_o;
    logic        mem_ready_i;
    logic [31:0] mem_data_i;
    logic        inst_valid_o;
    logic [31:0] inst_o;
    logic [31:0] inst_pc_o;

    int n_tests = 0;
    int n_fail  = 0;

    fetch_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .stall_i      (stall_i),
        .redirect_i   (redirect_i),
        .redirect_pc_i(redirect_pc_i),
        .mem_en_o     (mem_en_o),
        .mem_addr_o   (mem_addr_o),
        .mem_ready_i  (mem_ready_i),
        .mem_data_i   (mem_data_i),
        .inst_valid_o (inst_valid_o),
        .inst_o       (inst_o),
        .inst_pc_o    (inst_pc_o)
    );

    always #5 clk = ~clk;

    // Memory contents are a fixed function of the word address.
    function automatic logic [31:0] md(input logic [31:0] a);
        return a ^ 32'hA5A5_0F0F;
    endfunction

    assign mem_data_i = md(mem_addr_o);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic chk_inst(input string tag, input logic [31:0] pc);
        check({tag, ".valid"}, {31'd0, inst_valid_o}, 32'd1);
        check({tag, ".pc"}, inst_pc_o, pc);
        check({tag, ".inst"}, inst_o, md(pc));
    endtask

    task automatic chk_empty(input string tag);
        check({tag, ".valid"}, {31'd0, inst_valid_o}, 32'd0);
        check({tag, ".inst"}, inst_o, 32'd0);
        check({tag, ".pc"}, inst_pc_o, 32'd0);
    endtask

    task automatic chk_mem(input string tag, input logic en, input logic [31:0] addr);
        check({tag, ".en"}, {31'd0, mem_en_o}, {31'd0, en});
        check({tag, ".addr"}, mem_addr_o, addr);
    endtask

    initial begin
        rst_n         = 1'b0;
        stall_i       = 1'b0;
        redirect_i    = 1'b0;
        redirect_pc_i = 32'd0;
        mem_ready_i   = 1'b1;

        // Reset state
        @(negedge clk);
        chk_mem("rst", 1'b0, 32'hBFC0_0000);
        chk_empty("rst");
        @(negedge clk);
        rst_n = 1'b1;

        // Zero-wait streaming
        @(negedge clk);
        chk_mem("c1", 1'b1, 32'hBFC0_0000);
        chk_empty("c1");
        @(negedge clk);
        chk_inst("c2", 32'hBFC0_0000);
        @(negedge clk);
        chk_inst("c3", 32'hBFC0_0004);
        @(negedge clk);
        chk_inst("c4", 32'hBFC0_0008);

        // Stall fills the buffer and parks the fetcher in HOLD
        stall_i = 1'b1;
        @(negedge clk);
        chk_mem("hold1", 1'b0, 32'hBFC0_0010);
        chk_inst("hold1", 32'hBFC0_0008);
        @(negedge clk);
        chk_mem("hold2", 1'b0, 32'hBFC0_0010);
        chk_inst("hold2", 32'hBFC0_0008);
        stall_i = 1'b0;
        @(negedge clk);
        chk_mem("rel1", 1'b1, 32'hBFC0_0010);
        chk_inst("rel1", 32'hBFC0_000C);
        @(negedge clk);
        chk_inst("rel2", 32'hBFC0_0010);

        // Redirect during a wait cycle squashes the in-flight response
        mem_ready_i   = 1'b0;
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h8000_0103;
        @(negedge clk);
        redirect_i = 1'b0;
        chk_mem("sq1", 1'b1, 32'hBFC0_0014);
        chk_empty("sq1");
        @(negedge clk);
        chk_mem("sq2", 1'b1, 32'hBFC0_0014);
        chk_empty("sq2");
        mem_ready_i = 1'b1;
        @(negedge clk);
        chk_mem("sq3", 1'b1, 32'h8000_0100);
        chk_empty("sq3");
        @(negedge clk);
        chk_inst("sq4", 32'h8000_0100);

        // Redirect with a full buffer and no stall
        stall_i = 1'b1;
        @(negedge clk);
        chk_mem("full", 1'b0, 32'h8000_0108);
        chk_inst("full", 32'h8000_0100);
        stall_i       = 1'b0;
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h0000_1000;
        @(negedge clk);
        redirect_i = 1'b0;
        chk_empty("rdf1");
        chk_mem("rdf1", 1'b1, 32'h0000_1000);
        @(negedge clk);
        chk_inst("rdf2", 32'h0000_1000);

        // PC wrap at the top of the address space
        redirect_i    = 1'b1;
        redirect_pc_i = 32'hFFFF_FFF8;
        @(negedge clk);
        redirect_i = 1'b0;
        chk_mem("wrap1", 1'b1, 32'hFFFF_FFF8);
        chk_empty("wrap1");
        @(negedge clk);
        chk_mem("wrap2", 1'b1, 32'hFFFF_FFFC);
        chk_inst("wrap2", 32'hFFFF_FFF8);
        @(negedge clk);
        chk_mem("wrap3", 1'b1, 32'h0000_0000);
        chk_inst("wrap3", 32'hFFFF_FFFC);

        // Second redirect while squashing replaces the pending target
        mem_ready_i   = 1'b0;
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h0000_00A0;
        @(negedge clk);
        redirect_pc_i = 32'h0000_00B1;
        @(negedge clk);
        redirect_i  = 1'b0;
        chk_mem("sq2nd", 1'b1, 32'h0000_0000);
        mem_ready_i = 1'b1;
        @(negedge clk);
        chk_mem("sq2nd.tgt", 1'b1, 32'h0000_00B0);
        chk_empty("sq2nd.tgt");

        // Asynchronous reset in the middle of a wait
        mem_ready_i = 1'b0;
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk_mem("arst", 1'b0, 32'hBFC0_0000);
        chk_empty("arst");
        @(negedge clk);
        mem_ready_i = 1'b1;
        rst_n       = 1'b1;
        @(negedge clk);
        chk_mem("rest1", 1'b1, 32'hBFC0_0000);
        chk_empty("rest1");
        @(negedge clk);
        chk_inst("rest2", 32'hBFC0_0000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
